// File: rtl/ss_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ss_display_scheduler
// Purpose  : Round-robin scheduler that shares one 4-digit seven-segment
//            display among four requesters. Each granted 16-bit BCD message
//            is faded in through the PWM blanking threshold, held at full
//            brightness for at least HOLD_CYCLES, then faded out once another
//            requester is waiting.
// Ports    : Clk        - system clock
//            nReset     - asynchronous, active-low reset
//            Req_Valid  - per-requester message valid (held until accepted)
//            Req_Data   - message i in Req_Data[16*i+15:16*i] = {BCD3..BCD0}
//            Req_Ready  - one-hot grant, combinational, nonzero only in IDLE
//            BCD3..BCD0 - registered digit values for SS_Driver
//            PWM        - registered blanking threshold (0 = full, 255 = off)
//            Grant_Id   - index of the requester currently displayed
//            Busy       - high whenever the scheduler is not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ss_display_scheduler #(
  parameter int FADE_STEP   = 8,
  parameter int STEP_DIV    = 1024,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic [3:0]  Req_Valid,
  input  logic [63:0] Req_Data,
  output logic [3:0]  Req_Ready,
  output logic [3:0]  BCD3,
  output logic [3:0]  BCD2,
  output logic [3:0]  BCD1,
  output logic [3:0]  BCD0,
  output logic [7:0]  PWM,
  output logic [1:0]  Grant_Id,
  output logic        Busy
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_IN  = 2'd1,
    S_HOLD     = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

  localparam logic [15:0] c_step_last = 16'(STEP_DIV - 1);
  localparam logic [26:0] c_hold_last = 27'(HOLD_CYCLES - 1);
  localparam logic [8:0]  c_fade_step = 9'(FADE_STEP);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_ptr,   w_ptr_nxt;
  logic [15:0] r_step,  w_step_nxt;
  logic [26:0] r_hold,  w_hold_nxt;
  logic [7:0]  r_pwm,   w_pwm_nxt;
  logic [15:0] r_bcd,   w_bcd_nxt;
  logic [1:0]  r_gid,   w_gid_nxt;

  logic        w_found;
  logic [1:0]  w_pick;
  logic        w_accept;
  logic        w_step_wrap;
  logic [8:0]  w_pwm_up;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!w_found && Req_Valid[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + 2'(i);
      end
    end
  end

  // nReset gating keeps Ready low for the whole reset pulse, not just after it.
  assign w_accept    = (r_state == S_IDLE) && nReset && w_found;
  assign Req_Ready   = w_accept ? (4'b0001 << w_pick) : 4'b0000;
  assign w_step_wrap = (r_step == c_step_last);
  // Ninth bit catches the overflow so the fade-out clamps instead of wrapping.
  assign w_pwm_up    = {1'b0, r_pwm} + c_fade_step;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_step_nxt  = r_step;
    w_hold_nxt  = r_hold;
    w_pwm_nxt   = r_pwm;
    w_bcd_nxt   = r_bcd;
    w_gid_nxt   = r_gid;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_bcd_nxt   = Req_Data[{w_pick, 4'b0000} +: 16];
          w_gid_nxt   = w_pick;
          w_ptr_nxt   = w_pick;
          w_step_nxt  = 16'd0;
          w_state_nxt = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        if (w_step_wrap) begin
          w_step_nxt = 16'd0;
          if ({1'b0, r_pwm} <= c_fade_step) begin
            w_pwm_nxt   = 8'd0;
            w_hold_nxt  = 27'd0;
            w_state_nxt = S_HOLD;
          end else begin
            w_pwm_nxt = r_pwm - c_fade_step[7:0];
          end
        end else begin
          w_step_nxt = r_step + 16'd1;
        end
      end
      S_HOLD: begin
        w_pwm_nxt = 8'd0;
        if (r_hold != c_hold_last) begin
          w_hold_nxt = r_hold + 27'd1;
        end else if (|Req_Valid) begin
          w_step_nxt  = 16'd0;
          w_state_nxt = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (w_step_wrap) begin
          w_step_nxt = 16'd0;
          if (w_pwm_up >= 9'd255) begin
            w_pwm_nxt   = 8'd255;
            w_state_nxt = S_IDLE;
          end else begin
            w_pwm_nxt = w_pwm_up[7:0];
          end
        end else begin
          w_step_nxt = r_step + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd3;
      r_step  <= 16'd0;
      r_hold  <= 27'd0;
      r_pwm   <= 8'd255;
      r_bcd   <= 16'd0;
      r_gid   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_step  <= w_step_nxt;
      r_hold  <= w_hold_nxt;
      r_pwm   <= w_pwm_nxt;
      r_bcd   <= w_bcd_nxt;
      r_gid   <= w_gid_nxt;
    end
  end

  assign {BCD3, BCD2, BCD1, BCD0} = r_bcd;
  assign PWM      = r_pwm;
  assign Grant_Id = r_gid;
  assign Busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ss_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ss_display_scheduler
// Purpose  : Directed self-checking bench for ss_display_scheduler. Instance A
//            uses FADE_STEP=64, STEP_DIV=4, HOLD_CYCLES=10; instance B uses
//            FADE_STEP=255, STEP_DIV=1 for the single-step saturation case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ss_display_scheduler;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instance A
  logic        nReset;
  logic [3:0]  Req_Valid;
  logic [63:0] Req_Data;
  logic [3:0]  Req_Ready;
  logic [3:0]  BCD3, BCD2, BCD1, BCD0;
  logic [7:0]  PWM;
  logic [1:0]  Grant_Id;
  logic        Busy;

  // Instance B
  logic        nReset_b;
  logic [3:0]  Req_Valid_b;
  logic [63:0] Req_Data_b;
  logic [3:0]  Req_Ready_b;
  logic [3:0]  BCD3_b, BCD2_b, BCD1_b, BCD0_b;
  logic [7:0]  PWM_b;
  logic [1:0]  Grant_Id_b;
  logic        Busy_b;

  ss_display_scheduler #(.FADE_STEP(64), .STEP_DIV(4), .HOLD_CYCLES(10)) u_dut_a (
    .Clk(Clk), .nReset(nReset), .Req_Valid(Req_Valid), .Req_Data(Req_Data),
    .Req_Ready(Req_Ready), .BCD3(BCD3), .BCD2(BCD2), .BCD1(BCD1), .BCD0(BCD0),
    .PWM(PWM), .Grant_Id(Grant_Id), .Busy(Busy)
  );

  ss_display_scheduler #(.FADE_STEP(255), .STEP_DIV(1), .HOLD_CYCLES(10)) u_dut_b (
    .Clk(Clk), .nReset(nReset_b), .Req_Valid(Req_Valid_b), .Req_Data(Req_Data_b),
    .Req_Ready(Req_Ready_b), .BCD3(BCD3_b), .BCD2(BCD2_b), .BCD1(BCD1_b), .BCD0(BCD0_b),
    .PWM(PWM_b), .Grant_Id(Grant_Id_b), .Busy(Busy_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One fade step on instance A: three cycles at the old level, then the new one.
  task automatic step_to(input logic [7:0] old_v, input logic [7:0] new_v);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pwm_wait", 64'(PWM), 64'(old_v));
    end
    tick();
    chk("pwm_step", 64'(PWM), 64'(new_v));
  endtask

  task automatic fade_in();
    step_to(8'd255, 8'd191);
    step_to(8'd191, 8'd127);
    step_to(8'd127, 8'd63);
    step_to(8'd63,  8'd0);
    chk("busy_hold", 64'(Busy), 64'd1);
  endtask

  task automatic fade_out();
    step_to(8'd0,   8'd64);
    step_to(8'd64,  8'd128);
    step_to(8'd128, 8'd192);
    step_to(8'd192, 8'd255);
    chk("busy_idle", 64'(Busy), 64'd0);
  endtask

  // Minimum hold: nine more HOLD cycles plus the cycle entering FADE_OUT at PWM=0.
  task automatic hold_min();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pwm_hold", 64'(PWM), 64'd0);
    end
  endtask

  task automatic message(input logic [1:0] id, input logic [15:0] bcd);
    chk("ready_rr", 64'(Req_Ready), 64'(4'b0001 << id));
    tick();
    chk("grant_id", 64'(Grant_Id), 64'(id));
    chk("bcd", 64'({BCD3, BCD2, BCD1, BCD0}), 64'(bcd));
    chk("busy_on", 64'(Busy), 64'd1);
    chk("ready_off", 64'(Req_Ready), 64'd0);
    fade_in();
    hold_min();
    fade_out();
  endtask

  initial begin
    nReset      = 1'b0;
    Req_Valid   = 4'b0001;
    Req_Data    = {16'hFEDC, 16'h5678, 16'h4321, 16'h1234};
    nReset_b    = 1'b0;
    Req_Valid_b = 4'b0000;
    Req_Data_b  = {16'h0000, 16'h0000, 16'h0909, 16'h9999};

    // ---- Reset state ----
    repeat (3) tick();
    chk("rst_pwm",   64'(PWM), 64'd255);
    chk("rst_bcd",   64'({BCD3, BCD2, BCD1, BCD0}), 64'd0);
    chk("rst_gid",   64'(Grant_Id), 64'd0);
    chk("rst_busy",  64'(Busy), 64'd0);
    chk("rst_ready", 64'(Req_Ready), 64'd0);

    // ---- Test 1: single message, fade in, indefinite hold ----
    nReset = 1'b1;
    #1;
    chk("t1_ready", 64'(Req_Ready), 64'd1);
    tick();
    chk("t1_bcd",  64'({BCD3, BCD2, BCD1, BCD0}), 64'h1234);
    chk("t1_gid",  64'(Grant_Id), 64'd0);
    chk("t1_busy", 64'(Busy), 64'd1);
    chk("t1_pwm",  64'(PWM), 64'd255);
    Req_Valid = 4'b0000;
    fade_in();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_hold", 64'(PWM), 64'd0);
    end
    chk("t1_persist", 64'({BCD3, BCD2, BCD1, BCD0}), 64'h1234);

    // ---- Test 2: all four requesting, round-robin 0,1,2,3,0 ----
    Req_Data  = {16'hFEDC, 16'h5678, 16'h4321, 16'h9870};
    Req_Valid = 4'b1111;
    tick();
    chk("t2_fo_entry", 64'(PWM), 64'd0);
    fade_out();
    message(2'd1, 16'h4321);
    message(2'd2, 16'h5678);
    message(2'd3, 16'hFEDC);
    chk("t2_ready0", 64'(Req_Ready), 64'd1);
    tick();
    chk("t2_gid0", 64'(Grant_Id), 64'd0);
    chk("t2_bcd0", 64'({BCD3, BCD2, BCD1, BCD0}), 64'h9870);

    // ---- Test 3: request appears 3 cycles into HOLD ----
    Req_Valid = 4'b0000;
    fade_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_a", 64'(PWM), 64'd0);
    end
    Req_Data[47:32] = 16'hA5C9;
    Req_Valid       = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_hold_b", 64'(PWM), 64'd0);
    end
    fade_out();
    chk("t3_ready", 64'(Req_Ready), 64'b0100);
    tick();
    chk("t3_gid", 64'(Grant_Id), 64'd2);
    chk("t3_bcd", 64'({BCD3, BCD2, BCD1, BCD0}), 64'hA5C9);

    // ---- Test 4: reset mid fade-in, pointer returns to requester 0 first ----
    Req_Valid = 4'b1001;
    step_to(8'd255, 8'd191);
    step_to(8'd191, 8'd127);
    nReset = 1'b0;
    #1;
    chk("t4_pwm",   64'(PWM), 64'd255);
    chk("t4_bcd",   64'({BCD3, BCD2, BCD1, BCD0}), 64'd0);
    chk("t4_busy",  64'(Busy), 64'd0);
    chk("t4_gid",   64'(Grant_Id), 64'd0);
    chk("t4_ready", 64'(Req_Ready), 64'd0);
    tick();
    chk("t4_no_acc", 64'({BCD3, BCD2, BCD1, BCD0}), 64'd0);
    nReset = 1'b1;
    #1;
    chk("t4_ready_ptr", 64'(Req_Ready), 64'd1);
    tick();
    chk("t4_gid_acc", 64'(Grant_Id), 64'd0);
    chk("t4_bcd_acc", 64'({BCD3, BCD2, BCD1, BCD0}), 64'h9870);
    Req_Valid = 4'b0000;
    step_to(8'd255, 8'd191);

    // ---- Test 5: FADE_STEP=255, STEP_DIV=1 ----
    nReset_b    = 1'b1;
    Req_Valid_b = 4'b0010;
    #1;
    chk("t5_ready", 64'(Req_Ready_b), 64'b0010);
    tick();
    chk("t5_gid", 64'(Grant_Id_b), 64'd1);
    chk("t5_bcd", 64'({BCD3_b, BCD2_b, BCD1_b, BCD0_b}), 64'h0909);
    chk("t5_pwm_acc", 64'(PWM_b), 64'd255);
    Req_Valid_b = 4'b0001;
    tick();
    chk("t5_pwm_down", 64'(PWM_b), 64'd0);
    chk("t5_busy", 64'(Busy_b), 64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold", 64'(PWM_b), 64'd0);
    end
    tick();
    chk("t5_pwm_up", 64'(PWM_b), 64'd255);
    chk("t5_idle", 64'(Busy_b), 64'd0);
    chk("t5_ready2", 64'(Req_Ready_b), 64'b0001);
    tick();
    chk("t5_gid2", 64'(Grant_Id_b), 64'd0);
    chk("t5_bcd2", 64'({BCD3_b, BCD2_b, BCD1_b, BCD0_b}), 64'h9999);
    Req_Valid_b = 4'b0000;
    tick();
    chk("t5_pwm_down2", 64'(PWM_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
